// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock, full 2W-bit
// product plus a selectable W-bit half, start/busy/done handshake.
module booth_r4_mul #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     mode,
    input  logic           hi_sel,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   result
);

    localparam int N  = W / 2 + 1;
    localparam int CW = $clog2(N + 1);
    localparam int H  = W + 4;
    localparam int AW = 2 * W + 7;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    // acc = {upper partial sum (H), extended multiplier (W+2), Booth bit -1}
    logic [AW-1:0]   acc;
    logic [W+1:0]    a_ext;
    logic            hi_lat;
    logic [CW-1:0]   cnt;

    logic            sign_a, sign_b, last;
    logic [W+1:0]    a_in_ext, b_in_ext;
    logic [H-1:0]    a_h, addend, hi_sum;
    logic signed [AW-1:0] acc_sum, acc_step;

    assign sign_a   = (mode == 2'b01) || (mode == 2'b10);
    assign sign_b   = (mode == 2'b01);
    assign a_in_ext = {{2{sign_a & a[W-1]}}, a};
    assign b_in_ext = {{2{sign_b & b[W-1]}}, b};
    assign a_h      = {{2{a_ext[W+1]}}, a_ext};
    assign last     = (cnt == CW'(N));

    always_comb begin
        addend = '0;
        unique case (acc[2:0])
            3'b001, 3'b010: addend = a_h;
            3'b011:         addend = a_h << 1;
            3'b100:         addend = -(a_h << 1);
            3'b101, 3'b110: addend = -a_h;
            default:        addend = '0;
        endcase
    end

    assign hi_sum   = acc[AW-1:W+3] + addend;
    assign acc_sum  = {hi_sum, acc[W+2:0]};
    assign acc_step = acc_sum >>> 2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CALC) || (state == DONE);
    assign done = (state == DONE);

    // N digit cycles, then a terminal-count cycle that publishes the product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            a_ext   <= '0;
            hi_lat  <= 1'b0;
            cnt     <= '0;
            product <= '0;
            result  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_ext  <= a_in_ext;
                        acc    <= {{H{1'b0}}, b_in_ext, 1'b0};
                        hi_lat <= hi_sel;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (!last) begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                    end else begin
                        product <= acc[2*W:1];
                        result  <= hi_lat ? acc[2*W:W+1] : acc[W:1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul: W=32 and W=8 instances checked every cycle against a
// latency/arithmetic model, plus hand-computed literal products and latencies.
module tb_booth_r4_mul;

    logic        clk, rst;
    logic        start32, hs32, busy32, done32;
    logic [31:0] a32, b32, res32;
    logic [1:0]  mode32;
    logic [63:0] prod32;
    logic        start8, hs8, busy8, done8;
    logic [7:0]  a8, b8, res8;
    logic [1:0]  mode8;
    logic [15:0] prod8;

    int n_checks = 0;
    int n_err    = 0;

    booth_r4_mul #(.W(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .mode(mode32),
        .hi_sel(hs32), .busy(busy32), .done(done32), .product(prod32), .result(res32)
    );

    booth_r4_mul #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .mode(mode8),
        .hi_sel(hs8), .busy(busy8), .done(done8), .product(prod8), .result(res8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Exact product of the mode-extended operands, reduced mod 2^(2w)
    function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                             input logic [1:0] md, input int w);
        logic [127:0] mask, ex, ey;
        mask = (128'd1 << w) - 128'd1;
        ex = {64'd0, x} & mask;
        ey = {64'd0, y} & mask;
        if ((md == 2'b01 || md == 2'b10) && x[w-1]) ex = ex | ~mask;
        if (md == 2'b01 && y[w-1]) ey = ey | ~mask;
        return (ex * ey) & ((128'd1 << (2 * w)) - 128'd1);
    endfunction

    // Model: accepted at edge k, busy through done, done after edge k+N+1
    bit           m_busy [2] = '{0, 0};
    bit           m_done [2] = '{0, 0};
    int           m_cnt  [2] = '{0, 0};
    bit           m_hi   [2] = '{0, 0};
    logic [127:0] m_pend [2] = '{128'd0, 128'd0};
    logic [127:0] m_prod [2] = '{128'd0, 128'd0};
    logic [127:0] m_res  [2] = '{128'd0, 128'd0};

    task automatic model_step(input int d, input logic st, input logic [63:0] x,
                              input logic [63:0] y, input logic [1:0] md,
                              input logic hs, input int w);
        if (m_busy[d]) begin
            if (m_done[d]) begin
                m_busy[d] = 0;
                m_done[d] = 0;
            end else begin
                m_cnt[d]++;
                if (m_cnt[d] == w / 2 + 2) begin
                    m_done[d] = 1;
                    m_prod[d] = m_pend[d];
                    m_res[d]  = m_hi[d] ? (m_pend[d] >> w) : (m_pend[d] & ((128'd1 << w) - 128'd1));
                end
            end
        end else if (st) begin
            m_busy[d] = 1;
            m_cnt[d]  = 0;
            m_pend[d] = ref_mul(x, y, md, w);
            m_hi[d]   = hs;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
                m_prod[d] = '0; m_res[d] = '0;
            end
        end else begin
            model_step(0, start32, {32'd0, a32}, {32'd0, b32}, mode32, hs32, 32);
            model_step(1, start8, {56'd0, a8}, {56'd0, b8}, mode8, hs8, 8);
        end
    end

    always @(negedge clk) begin
        check("busy32", {127'd0, busy32}, {127'd0, m_busy[0]});
        check("done32", {127'd0, done32}, {127'd0, m_done[0]});
        check("product32", {64'd0, prod32}, m_prod[0]);
        check("result32", {96'd0, res32}, m_res[0]);
        check("busy8", {127'd0, busy8}, {127'd0, m_busy[1]});
        check("done8", {127'd0, done8}, {127'd0, m_done[1]});
        check("product8", {112'd0, prod8}, m_prod[1]);
        check("result8", {120'd0, res8}, m_res[1]);
    end

    // Operands keep changing after acceptance; restart pulses only if repulse
    task automatic op32(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] tm,
                        input logic th, input bit repulse, output int lat);
        @(negedge clk);
        a32 = ta; b32 = tb; mode32 = tm; hs32 = th; start32 = 1'b1;
        @(negedge clk);
        start32 = repulse;
        lat = 0;
        while (!done32 && lat < 40) begin
            a32 = $urandom; b32 = $urandom; mode32 = 2'($urandom); hs32 = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                       input logic th, output int lat);
        @(negedge clk);
        a8 = ta; b8 = tb; mode8 = tm; hs8 = th; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, extra_done;
        rst = 1'b1;
        start32 = 0; a32 = 0; b32 = 0; mode32 = 0; hs32 = 0;
        start8 = 0; a8 = 0; b8 = 0; mode8 = 0; hs8 = 0;
        #2;
        check("rst_busy", {127'd0, busy32}, 128'd0);
        check("rst_product", {64'd0, prod32}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op32(32'd7, 32'hFFFF_FFFD, 2'b01, 1'b0, 0, lat);
        check("lat_7x-3", lat, 18);
        check("prod_7x-3", {64'd0, prod32}, 128'hFFFF_FFFF_FFFF_FFEB);
        check("res_7x-3", {96'd0, res32}, 128'hFFFF_FFEB);

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 0, lat);
        check("prod_uu_max", {64'd0, prod32}, 128'hFFFF_FFFE_0000_0001);
        check("res_uu_max_hi", {96'd0, res32}, 128'hFFFF_FFFE);

        op32(32'h8000_0000, 32'h8000_0000, 2'b01, 1'b0, 0, lat);
        check("prod_ss_minneg", {64'd0, prod32}, 128'h4000_0000_0000_0000);

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b1, 0, lat);
        check("res_su_hi", {96'd0, res32}, 128'hFFFF_FFFF);
        check("prod_su", {64'd0, prod32}, 128'hFFFF_FFFF_0000_0001);

        op32(32'hFFFF_FFFF, 32'd2, 2'b11, 1'b1, 0, lat);
        check("prod_mode11", {64'd0, prod32}, 128'h1_FFFF_FFFE);
        check("res_mode11_hi", {96'd0, res32}, 128'h1);

        op32(32'd12345, 32'd1000, 2'b01, 1'b0, 1, lat);
        check("lat_repulse", lat, 18);
        check("prod_repulse", {64'd0, prod32}, 128'd12345000);
        extra_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done32) extra_done++;
        end
        check("repulse_no_extra_done", extra_done, 0);

        @(negedge clk);
        a32 = 32'd3; b32 = 32'd5; mode32 = 2'b00; hs32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {127'd0, busy32}, 128'd0);
        check("abort_done", {127'd0, done32}, 128'd0);
        check("abort_product", {64'd0, prod32}, 128'd0);
        check("abort_result", {96'd0, res32}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        a32 = 32'hFFFF_FFFE; b32 = 32'd9; mode32 = 2'b01; hs32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("lat_after_rst", lat, 18);
        check("prod_after_rst", {64'd0, prod32}, 128'hFFFF_FFFF_FFFF_FFEE);

        op8(8'h80, 8'h80, 2'b01, 1'b0, lat);
        check("lat8", lat, 6);
        check("prod8_minneg", {112'd0, prod8}, 128'h4000);
        op8(8'hFF, 8'hFF, 2'b00, 1'b1, lat);
        check("prod8_uu_max", {112'd0, prod8}, 128'hFE01);
        check("res8_uu_hi", {120'd0, res8}, 128'hFE);

        for (int i = 0; i < 2000; i++) begin
            op8(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), lat);
            check("lat8_rand", lat, 6);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
